// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector multiply engine.
//   state_e         : engine FSM states
//   default_acc_w() : default accumulator width (2*data_w + 8 guard bits)
//   ROWS_ADDR, COLS_ADDR, DATA_BASE : matrix-memory header layout
package matvec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StCheck,
    StRow,
    StStream,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned ROWS_ADDR = 0;
  localparam int unsigned COLS_ADDR = 1;
  localparam int unsigned DATA_BASE = 2;

  function automatic int unsigned default_acc_w(input int unsigned data_w);
    return 2 * data_w + 8;
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Signed multiply-accumulate with DATA_W output reduction.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : zero the accumulator (has priority over en_i)
//   en_i          : accumulate a_i * b_i
//   a_i, b_i      : signed operands
//   y_o           : accumulator reduced to DATA_W
// Build option MATVEC_SAT_EN: clamp y_o to the signed DATA_W range instead of wrapping.
// The accumulator itself never saturates.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = default_acc_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int unsigned ProdW = 2 * DATA_W;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ProdW-1:0] prod;

  assign prod = $signed(a_i) * $signed(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      // Size cast of a signed value sign-extends the full product.
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef MATVEC_SAT_EN
  // In range when every bit from the DATA_W sign bit upward agrees.
  logic in_range;
  assign in_range = (&acc_q[ACC_W-1:DATA_W-1]) | ~(|acc_q[ACC_W-1:DATA_W-1]);

  always_comb begin
    if (in_range) begin
      y_o = acc_q[DATA_W-1:0];
    end else if (acc_q[ACC_W-1]) begin
      y_o = {1'b1, {(DATA_W - 1) {1'b0}}};
    end else begin
      y_o = {1'b0, {(DATA_W - 1) {1'b1}}};
    end
  end
`else
  assign y_o = acc_q[DATA_W-1:0];
`endif

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: y = M * x.
// Matrix memory holds rows at word 0, cols at word 1, then M column-major from word 2.
// x(j) is read from vector address j; y(i) is written to result address i.
//   clk, rst_n             : clock, synchronous active-low reset
//   start                  : begin an operation (sampled only when idle)
//   m_rd/m_addr/m_rdata    : matrix memory, synchronous read (data next cycle)
//   v_rd/v_addr/v_rdata    : vector memory, same protocol
//   r_we/r_addr/r_wdata    : result memory write port
//   busy, done, err        : status; err flags illegal dimensions, valid with done
//   clock_count            : busy cycles of the last/current operation
// Build option MATVEC_SAT_EN (in matvec_mac): saturate results instead of wrapping.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ACC_W  = default_acc_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              v_rd,
  output logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_rdata,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       clock_count
);

  localparam int unsigned ProdW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              mac_clr, mac_en;
  logic [DATA_W-1:0] mac_y;
  logic [ProdW-1:0]  rows_w, cols_w, area, limit;
  logic              dim_bad, last_col, last_row;

  // Dimension check in double width so rows*cols cannot overflow.
  assign rows_w  = ProdW'(rows_q);
  assign cols_w  = ProdW'(cols_q);
  assign area    = rows_w * cols_w + ProdW'(2);
  assign limit   = ProdW'(1) << ADDR_W;
  assign dim_bad = (rows_q == '0) || (cols_q == '0) || (rows_w > limit) || (area > limit);

  assign last_col = (DATA_W'(j_q) == cols_q - DATA_W'(1));
  assign last_row = (DATA_W'(i_q) == rows_q - DATA_W'(1));

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = (state_q != StIdle) ? cnt_q + 32'd1 : cnt_q;
    m_rd    = 1'b0;
    m_addr  = '0;
    v_rd    = 1'b0;
    v_addr  = '0;
    r_we    = 1'b0;
    r_addr  = '0;
    r_wdata = '0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_rd    = 1'b1;
          m_addr  = ADDR_W'(ROWS_ADDR);
          err_d   = 1'b0;
          cnt_d   = 32'd1;  // the accepting cycle counts as busy
          state_d = StHdr0;
        end
      end
      StHdr0: begin
        rows_d  = m_rdata;
        m_rd    = 1'b1;
        m_addr  = ADDR_W'(COLS_ADDR);
        state_d = StHdr1;
      end
      StHdr1: begin
        cols_d  = m_rdata;
        state_d = StCheck;
      end
      StCheck: begin
        if (dim_bad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          i_d     = '0;
          state_d = StRow;
        end
      end
      StRow: begin
        mac_clr = 1'b1;
        j_d     = '0;
        addr_d  = ADDR_W'(DATA_BASE) + i_q;
        m_rd    = 1'b1;
        m_addr  = addr_d;
        v_rd    = 1'b1;
        v_addr  = '0;
        state_d = StStream;
      end
      StStream: begin
        mac_en = 1'b1;
        if (!last_col) begin
          // Next column of the same row is one full column (rows words) further on.
          addr_d = addr_q + rows_q[ADDR_W-1:0];
          m_rd   = 1'b1;
          m_addr = addr_d;
          j_d    = j_q + ADDR_W'(1);
          v_rd   = 1'b1;
          v_addr = j_d;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        r_we    = 1'b1;
        r_addr  = i_q;
        r_wdata = mac_y;
        if (last_row) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = StRow;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rows_q  <= '0;
      cols_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err         = err_q;
  assign clock_count = cnt_q;

  matvec_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (m_rdata),
    .b_i   (v_rdata),
    .y_o   (mac_y)
  );

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Hardware matrix-vector multiply engine computing y = M·x from column-major matrix memory and a vector memory, writing y to a result memory. It replaces the software loop the CPU testbench checks against. Parametrised in data and address width, it reads the rows/cols header itself, flags illegal dimensions, and reports an elapsed cycle count. It sits beside RISCVCPU as a memory-mapped accelerator.

## Interface
- DATA_W, 32, signed element width
- ADDR_W, 10, address width of all three memories
- ACC_W, 2*DATA_W+8, accumulator width
- clk  in  1  rising-edge clock; one clock, no other domains
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  begin operation; sampled only in IDLE
- m_rd, m_addr  out  1, ADDR_W  matrix memory read; synchronous read, data valid next cycle
- m_rdata  in  DATA_W  matrix read data
- v_rd, v_addr  out  1, ADDR_W  vector memory read, same protocol
- v_rdata  in  DATA_W  vector read data
- r_we, r_addr, r_wdata  out  1, ADDR_W, DATA_W  result memory write port
- busy  out  1  high from start acceptance until the DONE cycle inclusive
- done  out  1  one-cycle pulse in DONE
- err  out  1  illegal-dimension flag; valid with done, held until next start
- clock_count  out  32  cycles of the last/current operation

## Operation
- Memory map: matrix word 0 = rows, word 1 = cols, M(i,j) at 2 + i + j*rows; x(j) at vector address j; y(i) written to result address i.
- IDLE: start=1 → issue m_addr=0, clear clock_count and err, go HDR0.
- HDR0: capture rows from m_rdata; issue m_addr=1 → HDR1.
- HDR1: capture cols → CHECK.
- CHECK: err if rows==0, cols==0, rows > 2^ADDR_W, or rows*cols+2 > 2^ADDR_W (compute in 2*DATA_W bits). err → DONE with err=1, no result writes; else i=0 → ROW.
- ROW: acc=0, j=0; issue m_addr=2+i, v_addr=0 → STREAM.
- STREAM (cols cycles): acc += m_rdata*v_rdata (full signed product, sign-extended to ACC_W); while j<cols-1 issue m_addr += rows, v_addr = j+1; after the last MAC → WRITE.
- WRITE: r_we=1, r_addr=i, r_wdata = acc reduced to DATA_W (see Configuration); i<rows-1 → ROW with i+1, else → DONE.
- DONE: done=1 → IDLE.
- start outside IDLE is ignored. Read enables are high only on cycles an address is issued.

## Timing
- Reset: state IDLE; all outputs 0, including clock_count, err, addresses, r_wdata.
- Reset mid-operation: IDLE the next cycle, no further writes, clock_count=0.
- clock_count increments every busy cycle, holds after done until the next start.
- Total latency, start cycle through DONE inclusive: 5 + rows*(cols+2); error case: 5.
- Exactly one result write per row, in row order, ADDR_W-bit addresses, no wrap beyond the checked range.

## Configuration
- MATVEC_SAT_EN defined: r_wdata clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] if acc is out of range.
- Undefined: r_wdata = acc[DATA_W-1:0] (two's-complement wrap). Accumulation is never saturated internally in either build.

## Structure
- matvec_pkg: state enum (IDLE, HDR0, HDR1, CHECK, ROW, STREAM, WRITE, DONE), default ACC_W function, header address constants (ROWS_ADDR=0, COLS_ADDR=1, DATA_BASE=2).
- Sub-module matvec_mac: clear/enable signed multiply-accumulate plus the DATA_W output reduction (the MATVEC_SAT_EN clamp lives here). FSM and address counters stay in matvec_engine.

## Test plan
- rows=2, cols=2, matrix words 2..5 = 1,3,2,4, x=[5,6] → writes y0=17 at r_addr 0, y1=39 at r_addr 1; done pulse; clock_count=13; err=0.
- rows=1, cols=3, M=[-1,-2,-3], x=[4,5,6] → y0=-32 (0xFFFFFFE0); clock_count=10.
- rows=0 → err=1, done on cycle 5, no r_we, clock_count=5; the next valid start clears err.
- rows=1, cols=2, M=[0x7FFFFFFF,0x7FFFFFFF], x=[2,2] → with MATVEC_SAT_EN y0=0x7FFFFFFF; without, y0=0xFFFFFFFC.
- rows=3, cols=4: pulse start during STREAM → ignored, results unchanged; assert rst_n=0 during row 1 → IDLE next cycle, no further writes, outputs 0.
- rows*cols+2=1025 with ADDR_W=10 → err=1; rows=32, cols=31 → all 32 results match the software model, clock_count=5+32*33.
